// File: rtl/data_dir_dram_bridge.sv
// Single-outstanding bridge from Program's Data_No requests to the DRAM AXI4-Lite slave.
// Packs/unpacks the 57-bit Data_Dir struct to/from one 64-bit DRAM word.
//
// Data_Dir vector layout (57 bits):
//   [56:45] Index_A  [44:33] Index_B  [32:29] M  [28:17] Index_C  [16:5] Index_D  [4:0] D
module data_dir_dram_bridge #(
    parameter int unsigned       ADDR_W    = 17,
    parameter int unsigned       DATA_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 17'h10000
) (
    input  logic              clk,
    input  logic              rst_n,
    // request / response towards Program
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [7:0]        req_data_no,
    input  logic [56:0]       req_wdata,
    output logic              rsp_valid,
    output logic [56:0]       rsp_rdata,
    output logic              rsp_err,
    // AXI read address
    output logic              ar_valid,
    output logic [ADDR_W-1:0] ar_addr,
    input  logic              ar_ready,
    // AXI read data
    input  logic              r_valid,
    input  logic [DATA_W-1:0] r_data,
    input  logic [1:0]        r_resp,
    output logic              r_ready,
    // AXI write address
    output logic              aw_valid,
    output logic [ADDR_W-1:0] aw_addr,
    input  logic              aw_ready,
    // AXI write data
    output logic              w_valid,
    output logic [DATA_W-1:0] w_data,
    input  logic              w_ready,
    // AXI write response
    input  logic              b_valid,
    input  logic [1:0]        b_resp,
    output logic              b_ready
);

    typedef enum logic [2:0] {
        DRAM_IDLE,
        R_ADDR,
        R_DATA,
        W_ADDR,
        W_DATA,
        WAIT_RESP
    } dram_state_e;

    dram_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [56:0]       wdata_q;
    logic [56:0]       rdata_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic              accept;
    logic [56:0]       rdata_unpacked;

    // Pad bits above the 4-bit M and 5-bit D fields are not part of Data_Dir.
    logic unused_pad;
    assign unused_pad = ^{r_data[39:36], r_data[7:5]};

    // Bridge is busy for the rsp_valid cycle so a new request never overlaps the pulse.
    assign req_ready = (state_q == DRAM_IDLE) && !rsp_valid_q;
    assign accept    = req_valid && req_ready;

    assign rdata_unpacked = {r_data[63:52], r_data[51:40], r_data[35:32],
                             r_data[31:20], r_data[19:8],  r_data[4:0]};

    assign ar_addr   = addr_q;
    assign aw_addr   = addr_q;
    assign w_data    = {wdata_q[56:45], wdata_q[44:33], 4'b0000, wdata_q[32:29],
                        wdata_q[28:17], wdata_q[16:5],  3'b000,  wdata_q[4:0]};
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rsp_err_q;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DRAM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and AXI channel control; handshakes advance in the same cycle.
    always_comb begin
        state_d  = state_q;
        ar_valid = 1'b0;
        r_ready  = 1'b0;
        aw_valid = 1'b0;
        w_valid  = 1'b0;
        b_ready  = 1'b0;
        unique case (state_q)
            DRAM_IDLE: begin
                if (accept) begin
                    state_d = req_write ? W_ADDR : R_ADDR;
                end
            end
            R_ADDR: begin
                ar_valid = 1'b1;
                if (ar_ready) begin
                    state_d = R_DATA;
                end
            end
            R_DATA: begin
                r_ready = 1'b1;
                if (r_valid) begin
                    state_d = DRAM_IDLE;
                end
            end
            W_ADDR: begin
                aw_valid = 1'b1;
                if (aw_ready) begin
                    state_d = W_DATA;
                end
            end
            W_DATA: begin
                w_valid = 1'b1;
                if (w_ready) begin
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                b_ready = 1'b1;
                if (b_valid) begin
                    state_d = DRAM_IDLE;
                end
            end
            default: begin
                state_d = DRAM_IDLE;
            end
        endcase
    end

    // Request capture and response registers; rsp_valid is a single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (accept) begin
                addr_q <= BASE_ADDR + ADDR_W'({req_data_no, 3'b000});
                if (req_write) begin
                    wdata_q <= req_wdata;
                end
            end
            if ((state_q == R_DATA) && r_valid) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= |r_resp;
                rdata_q     <= rdata_unpacked;
            end
            if ((state_q == WAIT_RESP) && b_valid) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= |b_resp;
            end
        end
    end

endmodule

// File: tb/tb_data_dir_dram_bridge.sv
// Scoreboard bench for data_dir_dram_bridge: directed requests, a delay-configurable AXI
// slave model, and a response monitor that pops expected results from a queue.
module tb_data_dir_dram_bridge;

    typedef struct {
        logic [56:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [7:0]  req_data_no = '0;
    logic [56:0] req_wdata = '0;
    logic        rsp_valid;
    logic [56:0] rsp_rdata;
    logic        rsp_err;
    logic        ar_valid;
    logic [16:0] ar_addr;
    logic        ar_ready = 1'b0;
    logic        r_valid = 1'b0;
    logic [63:0] r_data = '0;
    logic [1:0]  r_resp = '0;
    logic        r_ready;
    logic        aw_valid;
    logic [16:0] aw_addr;
    logic        aw_ready = 1'b0;
    logic        w_valid;
    logic [63:0] w_data;
    logic        w_ready = 1'b0;
    logic        b_valid = 1'b0;
    logic [1:0]  b_resp = '0;
    logic        b_ready;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int rsp_cyc = 0;
    bit b2b_chk = 1'b0;
    int n_ar = 0, n_aw = 0, n_w = 0, n_b = 0;

    // slave configuration, set by the stimulus before each request
    int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [63:0] rd_word = '0;
    logic [1:0]  rd_resp = '0;
    logic [1:0]  wr_resp = '0;
    logic [56:0] last_rd = '0;

    logic [16:0] exp_addr[$];
    logic [63:0] exp_wd[$];
    exp_t        exp_q[$];

    data_dir_dram_bridge dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_data_no(req_data_no),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .ar_valid   (ar_valid),
        .ar_addr    (ar_addr),
        .ar_ready   (ar_ready),
        .r_valid    (r_valid),
        .r_data     (r_data),
        .r_resp     (r_resp),
        .r_ready    (r_ready),
        .aw_valid   (aw_valid),
        .aw_addr    (aw_addr),
        .aw_ready   (aw_ready),
        .w_valid    (w_valid),
        .w_data     (w_data),
        .w_ready    (w_ready),
        .b_valid    (b_valid),
        .b_resp     (b_resp),
        .b_ready    (b_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- AXI slave model ----------------
    task automatic serve_read();
        logic [16:0] a0;
        a0 = ar_addr;
        for (int i = 0; i < ar_dly; i++) begin
            check("ar_hold", 64'(ar_valid && (ar_addr == a0) && !aw_valid), 64'd1);
            @(negedge clk);
            if (!rst_n) return;
        end
        check("ar_valid", 64'(ar_valid), 64'd1);
        if (exp_addr.size() == 0) check("ar_addr_unexpected", 64'd1, 64'd0);
        else check("ar_addr", 64'(ar_addr), 64'(exp_addr.pop_front()));
        ar_ready = 1'b1;
        @(posedge clk);
        #1 ar_ready = 1'b0;
        for (int i = 0; i <= r_dly; i++) begin
            @(negedge clk);
            if (!rst_n) return;
        end
        r_valid = 1'b1;
        r_data  = rd_word;
        r_resp  = rd_resp;
        for (int n = 0; n < 100 && !r_ready; n++) begin
            @(negedge clk);
            if (!rst_n) begin
                r_valid = 1'b0;
                return;
            end
        end
        check("r_ready", 64'(r_ready), 64'd1);
        @(posedge clk);
        #1;
        r_valid = 1'b0;
        r_data  = '0;
        r_resp  = '0;
    endtask

    task automatic serve_write();
        logic [16:0] a0;
        logic [63:0] d0;
        a0 = aw_addr;
        for (int i = 0; i < aw_dly; i++) begin
            check("aw_hold", 64'(aw_valid && (aw_addr == a0) && !w_valid && !ar_valid), 64'd1);
            @(negedge clk);
            if (!rst_n) return;
        end
        check("aw_before_w", 64'({aw_valid, w_valid}), 64'd2);
        if (exp_addr.size() == 0) check("aw_addr_unexpected", 64'd1, 64'd0);
        else check("aw_addr", 64'(aw_addr), 64'(exp_addr.pop_front()));
        aw_ready = 1'b1;
        @(posedge clk);
        #1 aw_ready = 1'b0;
        @(negedge clk);
        if (!rst_n) return;
        d0 = w_data;
        for (int i = 0; i < w_dly; i++) begin
            check("w_hold", 64'(w_valid && (w_data == d0) && !aw_valid), 64'd1);
            @(negedge clk);
            if (!rst_n) return;
        end
        check("w_valid", 64'(w_valid), 64'd1);
        if (exp_wd.size() == 0) check("w_data_unexpected", 64'd1, 64'd0);
        else check("w_data", w_data, exp_wd.pop_front());
        w_ready = 1'b1;
        @(posedge clk);
        #1 w_ready = 1'b0;
        for (int i = 0; i <= b_dly; i++) begin
            @(negedge clk);
            if (!rst_n) return;
        end
        b_valid = 1'b1;
        b_resp  = wr_resp;
        for (int n = 0; n < 100 && !b_ready; n++) begin
            @(negedge clk);
            if (!rst_n) begin
                b_valid = 1'b0;
                return;
            end
        end
        check("b_ready", 64'(b_ready), 64'd1);
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        b_resp  = '0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && ar_valid) serve_read();
            else if (rst_n && aw_valid) serve_write();
        end
    end

    // cycle counter and per-channel handshake counters
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (ar_valid && ar_ready) n_ar++;
            if (aw_valid && aw_ready) n_aw++;
            if (w_valid && w_ready) n_w++;
            if (b_valid && b_ready) n_b++;
        end
    end

    // response monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && req_valid && req_ready) begin
                acc_cyc = cyc;
                if (b2b_chk) begin
                    check("b2b_gap", 64'(acc_cyc - rsp_cyc), 64'd1);
                    b2b_chk = 1'b0;
                end
            end
            if (rsp_valid) begin
                rsp_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    check("rsp_err", 64'(rsp_err), 64'(e.err));
                    if (e.lat >= 0) check("rsp_latency", 64'(cyc - acc_cyc), 64'(e.lat));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_req(input bit wr, input logic [7:0] no, input logic [56:0] wd,
                          input bit hold);
        int n;
        @(posedge clk);
        #1;
        req_valid   = 1'b1;
        req_write   = wr;
        req_data_no = no;
        req_wdata   = wd;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("req_accept", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic rd(input logic [7:0] no, input logic [16:0] addr, input logic [63:0] word,
                      input logic [1:0] resp, input logic [56:0] exp_rd, input int lat,
                      input bit hold);
        exp_t e;
        rd_word = word;
        rd_resp = resp;
        exp_addr.push_back(addr);
        e.rdata = exp_rd;
        e.err   = |resp;
        e.lat   = lat;
        exp_q.push_back(e);
        last_rd = exp_rd;
        do_req(1'b0, no, 57'h0, hold);
    endtask

    task automatic wr(input logic [7:0] no, input logic [16:0] addr, input logic [56:0] wd,
                      input logic [63:0] exp_word, input logic [1:0] resp, input int lat);
        exp_t e;
        wr_resp = resp;
        exp_addr.push_back(addr);
        exp_wd.push_back(exp_word);
        e.rdata = last_rd;
        e.err   = |resp;
        e.lat   = lat;
        exp_q.push_back(e);
        do_req(1'b1, no, wd, 1'b0);
    endtask

    task automatic set_dly(input int d);
        ar_dly = d;
        r_dly  = d;
        aw_dly = d;
        w_dly  = d;
        b_dly  = d;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
        check("rsp_drain", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        repeat (3) @(negedge clk);
        check("rst_valids", 64'({ar_valid, r_ready, aw_valid, w_valid, b_ready, rsp_valid,
                                 rsp_err}), 64'd0);
        check("rst_ar_addr", 64'(ar_addr), 64'd0);
        check("rst_aw_addr", 64'(aw_addr), 64'd0);
        check("rst_w_data", w_data, 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("idle_req_ready", 64'(req_ready), 64'd1);

        // zero-wait read of Data_No 0
        set_dly(0);
        rd(8'd0, 17'h10000, 64'hABC_DEF_05_123_456_1F, 2'b00,
           {12'hABC, 12'hDEF, 4'h5, 12'h123, 12'h456, 5'h1F}, 3, 1'b0);
        wait_idle();

        // zero-wait write of Data_No 255 (top of address range)
        wr(8'd255, 17'h107F8, {12'h001, 12'h002, 4'hC, 12'h003, 12'h004, 5'h1F},
           64'h001_002_0C_003_004_1F, 2'b00, 4);
        wait_idle();

        // 5-cycle slave delays on every channel; pad bits set in the read word
        set_dly(5);
        rd(8'd3, 17'h10018, 64'h123_456_F7_89A_BCD_E3, 2'b00,
           {12'h123, 12'h456, 4'h7, 12'h89A, 12'hBCD, 5'h03}, 13, 1'b0);
        wait_idle();
        wr(8'h80, 17'h10400, {12'hFFF, 12'h000, 4'hF, 12'hAAA, 12'h555, 5'h00},
           64'hFFF_000_0F_AAA_555_00, 2'b01, 19);
        wait_idle();

        // read error response
        set_dly(0);
        rd(8'd1, 17'h10008, 64'h800_001_0A_7FE_00C_11, 2'b10,
           {12'h800, 12'h001, 4'hA, 12'h7FE, 12'h00C, 5'h11}, 3, 1'b0);
        wait_idle();
        check("err_back_idle", 64'(req_ready), 64'd1);

        // back-to-back read then write with req_valid held high
        rd(8'd2, 17'h10010, 64'h111_222_03_333_444_15, 2'b00,
           {12'h111, 12'h222, 4'h3, 12'h333, 12'h444, 5'h15}, 3, 1'b1);
        b2b_chk = 1'b1;
        wr(8'd4, 17'h10020, {12'hAB1, 12'hCD2, 4'h1, 12'hEF3, 12'h012, 5'h0A},
           64'hAB1_CD2_01_EF3_012_0A, 2'b00, 4);
        wait_idle();
        check("b2b_done", 64'(b2b_chk), 64'd0);

        // reset asserted while the write sits in W_DATA
        w_dly = 10;
        wr(8'd5, 17'h10028, {12'h321, 12'h654, 4'h2, 12'h987, 12'hCBA, 5'h07},
           64'h321_654_02_987_CBA_07, 2'b00, -1);
        for (int n = 0; n < 50 && !w_valid; n++) @(negedge clk);
        check("reached_w_data", 64'(w_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valids", 64'({aw_valid, w_valid, b_ready, ar_valid, rsp_valid}), 64'd0);
        check("mid_rst_idle", 64'(req_ready), 64'd1);
        repeat (2) @(negedge clk);
        exp_q.delete();
        exp_wd.delete();
        exp_addr.delete();
        last_rd = '0;
        check("mid_rst_rdata", 64'(rsp_rdata), 64'd0);
        set_dly(0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // fresh read after reset
        rd(8'd6, 17'h10030, 64'h0FE_DCB_0A_987_654_0B, 2'b00,
           {12'h0FE, 12'hDCB, 4'hA, 12'h987, 12'h654, 5'h0B}, 3, 1'b0);
        wait_idle();

        check("n_ar_handshakes", 64'(n_ar), 64'd5);
        check("n_aw_handshakes", 64'(n_aw), 64'd4);
        check("n_w_handshakes", 64'(n_w), 64'd3);
        check("n_b_handshakes", 64'(n_b), 64'd3);
        check("final_rsp_valid", 64'(rsp_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
